// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe
// Description : One-entry decode stage. Holds a fetched instruction with its
//               sequential PC and control bundle, reads operands from a
//               2^RA_W x W register file with same-cycle writeback bypass,
//               interlocks on a load-use hazard against the load in execute,
//               and resolves jump / branch targets for the next fetch.
//
// Ports       : clk, reset (async, active-high)
//               in_valid / in_ready           upstream handshake
//               instr_in, pc_seq_in, bundle_in instruction, sequential PC,
//                                             control bundle
//               out_valid / out_ready         downstream handshake
//               operand_a_out, operand_b_out, reg_read2_out, pc_seq_out
//               reg_write_dest_out, bundle_out (held bundle[13:0])
//               jump_address_out, redirect_out next-fetch target / taken flag
//               wb_en_in, wb_dest_in, wb_data_in writeback port
//               ex_load_in, ex_dest_in        load currently in execute
//               stall_cycles_out              only with DECODE_PERF_CNT_EN
//
// Options     : DECODE_PERF_CNT_EN - adds a saturating stall-cycle counter.
//
// Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe #(
    parameter int W      = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic [W-1:0]      pc_seq_in,
    input  logic [CTRL_W-1:0] bundle_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      operand_a_out,
    output logic [W-1:0]      operand_b_out,
    output logic [W-1:0]      reg_read2_out,
    output logic [W-1:0]      pc_seq_out,
    output logic [RA_W-1:0]   reg_write_dest_out,
    output logic [13:0]       bundle_out,
    output logic [W-1:0]      jump_address_out,
    output logic              redirect_out,
    input  logic              wb_en_in,
    input  logic [RA_W-1:0]   wb_dest_in,
    input  logic [W-1:0]      wb_data_in,
    input  logic              ex_load_in,
    input  logic [RA_W-1:0]   ex_dest_in
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_out
`endif
);

    localparam int c_NUM_REGS = 1 << RA_W;

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    logic              r_held_valid;
    logic [31:0]       r_instr;
    logic [W-1:0]      r_pc_seq;
    logic [CTRL_W-1:0] r_bundle;

    logic w_hazard;
    logic w_fire;
    logic w_xfer;

    assign out_valid = r_held_valid & ~w_hazard;
    assign w_fire    = out_valid & out_ready;
    assign in_ready  = ~r_held_valid | w_fire;
    assign w_xfer    = in_valid & in_ready;

    // A hazard keeps out_valid low, which also keeps in_ready low while an
    // instruction is held, so the holding register retains its contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held_valid <= 1'b0;
            r_instr      <= '0;
            r_pc_seq     <= '0;
            r_bundle     <= '0;
        end else if (w_xfer) begin
            r_held_valid <= 1'b1;
            r_instr      <= instr_in;
            r_pc_seq     <= pc_seq_in;
            r_bundle     <= bundle_in;
        end else if (w_fire) begin
            r_held_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [RA_W-1:0] w_rs;
    logic [RA_W-1:0] w_rt;
    logic [RA_W-1:0] w_rd;
    logic [15:0]     w_imm16;
    logic [25:0]     w_imm26;
    logic [4:0]      w_shamt;

    assign w_rs    = RA_W'(r_instr[25:21]);
    assign w_rt    = RA_W'(r_instr[20:16]);
    assign w_rd    = RA_W'(r_instr[15:11]);
    assign w_imm16 = r_instr[15:0];
    assign w_imm26 = r_instr[25:0];
    assign w_shamt = r_instr[10:6];

    assign w_hazard = r_held_valid & ex_load_in & (ex_dest_in != '0) &
                      ((ex_dest_in == w_rs) | (ex_dest_in == w_rt));

    // ------------------------------------------------------------------
    // Register file (entry 0 is never written and always reads zero)
    // ------------------------------------------------------------------
    logic [W-1:0] r_regs [c_NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en_in && (wb_dest_in != '0)) begin
            r_regs[wb_dest_in] <= wb_data_in;
        end
    end

    logic [W-1:0] w_rs_val;
    logic [W-1:0] w_rt_val;

    // Writeback in the same cycle wins over the stored value.
    assign w_rs_val = (w_rs == '0) ? '0 :
                      (wb_en_in && (wb_dest_in == w_rs)) ? wb_data_in : r_regs[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 :
                      (wb_en_in && (wb_dest_in == w_rt)) ? wb_data_in : r_regs[w_rt];

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [W-1:0] w_imm16_ext;
    logic [W-1:0] w_imm_up;
    logic [W-1:0] w_imm_sel;

    assign w_imm16_ext = r_bundle[19] ? {{(W-16){1'b0}}, w_imm16}
                                      : {{(W-16){w_imm16[15]}}, w_imm16};
    // Upshifted form places imm16 in bits [31:16]; bit 19 also picks how a
    // wider datapath extends it.
    assign w_imm_up    = r_bundle[19] ? {{(W-32){1'b0}}, w_imm16, 16'h0000}
                                      : {{(W-32){w_imm16[15]}}, w_imm16, 16'h0000};
    // Jump-immediate path presents the raw 26-bit field zero-extended.
    assign w_imm_sel   = r_bundle[20] ? {{(W-26){1'b0}}, w_imm26} :
                         r_bundle[18] ? w_imm16_ext : w_imm_up;

    assign operand_a_out = r_bundle[16] ? {{(W-5){1'b0}}, w_shamt} : w_rs_val;
    assign operand_b_out = r_bundle[17] ? w_imm_sel : w_rt_val;
    assign reg_read2_out = w_rt_val;
    assign pc_seq_out    = r_pc_seq;
    assign bundle_out    = r_bundle[13:0];

    always_comb begin
        reg_write_dest_out = w_rt;
        case (r_bundle[15:14])
            2'b00:   reg_write_dest_out = w_rt;
            2'b01:   reg_write_dest_out = w_rd;
            2'b10:   reg_write_dest_out = '1;
            default: reg_write_dest_out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------
    logic         w_rs_le_zero;
    logic         w_cond;
    logic         w_taken;
    logic [W-1:0] w_branch_target;
    logic [W-1:0] w_jump_target;

    assign w_rs_le_zero = w_rs_val[W-1] | (w_rs_val == '0);

    always_comb begin
        w_cond = 1'b0;
        case (r_bundle[1:0])
            2'b00:   w_cond = (w_rs_val == w_rt_val);
            2'b01:   w_cond = (w_rs_val != w_rt_val);
            2'b10:   w_cond = w_rs_le_zero;
            default: w_cond = ~w_rs_le_zero;
        endcase
    end

    assign w_taken         = r_bundle[21] & w_cond;
    assign w_branch_target = r_pc_seq + {{(W-18){w_imm16[15]}}, w_imm16, 2'b00};
    assign w_jump_target   = r_bundle[23] ? {r_pc_seq[W-1:28], w_imm26, 2'b00} : w_rs_val;

    assign jump_address_out = r_bundle[22] ? w_jump_target :
                              w_taken      ? w_branch_target : r_pc_seq;

    assign redirect_out = w_fire & (r_bundle[22] | w_taken);

    // Opcode and upper bundle bits are consumed by later stages only.
    logic w_unused;
    assign w_unused = ^{r_instr[31:26], r_bundle[CTRL_W-1:24], r_bundle[7:2]};

    // ------------------------------------------------------------------
    // Optional stall-cycle counter
    // ------------------------------------------------------------------
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (r_held_valid && (w_hazard || !out_ready) &&
                     (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_out = r_stall_cycles;
`endif

endmodule
`default_nettype wire
